// File: rtl/datapath_pkg.sv
// Shared datapath definitions: bus word width, the default output-port FIFO
// depth and the bus word type.
package datapath_pkg;

  localparam int unsigned WORD_W        = 32;
  localparam int unsigned OUTPORT_DEPTH = 4;

  typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/fifo_mem.sv
// Register-array storage for the output-port FIFO.
// Ports:
//   clk_i    - clock; writes happen on the rising edge
//   we_i     - write enable
//   waddr_i  - write address
//   wdata_i  - write data
//   raddr_i  - read address (asynchronous read)
//   rdata_o  - word at raddr_i
module fifo_mem #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  // No reset: contents are only ever read through a valid head pointer.
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/out_port_fifo.sv
// CPU output port: words written by the out instruction are queued in a small
// FIFO and presented to an external consumer as a first-word fall-through
// valid/ready stream.
// Ports:
//   clock     - system clock
//   reset     - asynchronous active-low reset
//   wr_en     - CPU write strobe
//   wr_data   - word from the bus
//   clr_ovf   - synchronous clear of the overflow flag
//   out_valid - out_data holds a valid word
//   out_ready - consumer accepts the head word
//   out_data  - head word, zero when empty
//   full      - FIFO full, used to stall the CPU
//   empty     - FIFO empty
//   count     - current occupancy
//   overflow  - sticky: a write was dropped while full
module out_port_fifo
  import datapath_pkg::*;
#(
  parameter int unsigned WIDTH = WORD_W,
  parameter int unsigned DEPTH = OUTPORT_DEPTH,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             clr_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;

  logic             push;
  logic             pop;
  logic [WIDTH-1:0] head_data;

  // Status is decoded from the registered count only.
  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign out_valid = !empty;
  assign count     = count_q;
  assign overflow  = overflow_q;

  // A pop frees a slot in the same cycle, so a write to a full FIFO is
  // accepted when the consumer is draining.
  assign pop  = out_valid && out_ready;
  assign push = wr_en && (!full || pop);

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Set has priority over clear so a drop in the clearing cycle is kept.
    if (wr_en && full && !pop) begin
      overflow_d = 1'b1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  fifo_mem #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_mem (
    .clk_i   (clock),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (head_data)
  );

  assign out_data = empty ? '0 : head_data;

endmodule

// File: tb/tb_out_port_fifo.sv
module tb_out_port_fifo;
  import datapath_pkg::*;

  logic        clock;
  logic        reset;
  logic        wr_en;
  word_t       wr_data;
  logic        clr_ovf;
  logic        out_valid;
  logic        out_ready;
  word_t       out_data;
  logic        full;
  logic        empty;
  logic [2:0]  count;
  logic        overflow;

  int tests;
  int fails;

  out_port_fifo #(
    .WIDTH (32),
    .DEPTH (4),
    .CNT_W (3)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .clr_ovf   (clr_ovf),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock: inputs set before this call are sampled at the
  // rising edge, outputs are checked afterwards at the falling edge.
  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    logic [31:0] seq [4];
    tests     = 0;
    fails     = 0;
    reset     = 1'b0;
    wr_en     = 1'b0;
    wr_data   = '0;
    clr_ovf   = 1'b0;
    out_ready = 1'b0;

    // 1. Reset state
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_data", out_data, 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    step();

    // 2. Single write, held head, single read
    wr_en = 1'b1; wr_data = 32'h0000_00A5;
    step();
    wr_en = 1'b0;
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_data", out_data, 32'h0000_00A5);
    chk("single_count", 32'(count), 32'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_data", out_data, 32'h0000_00A5);
      chk("hold_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("single_empty", 32'(empty), 32'd1);
    chk("single_empty_data", out_data, 32'd0);

    // 3. Fill, partial drain, wrap
    for (int i = 1; i <= 4; i++) begin
      wr_en = 1'b1; wr_data = 32'(i * 32'h11);
      step();
    end
    wr_en = 1'b0;
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'd4);
    out_ready = 1'b1;
    chk("drain_0", out_data, 32'h11);
    step();
    chk("drain_1", out_data, 32'h22);
    step();
    out_ready = 1'b0;
    chk("drain_count", 32'(count), 32'd2);
    wr_en = 1'b1; wr_data = 32'h55;
    step();
    wr_data = 32'h66;
    step();
    wr_en = 1'b0;
    chk("wrap_full", 32'(full), 32'd1);
    seq[0] = 32'h33; seq[1] = 32'h44; seq[2] = 32'h55; seq[3] = 32'h66;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("wrap_seq", out_data, seq[i]);
      step();
    end
    out_ready = 1'b0;
    chk("wrap_empty", 32'(empty), 32'd1);

    // 4. Overflow
    for (int i = 1; i <= 4; i++) begin
      wr_en = 1'b1; wr_data = 32'h80 + 32'(i);
      step();
    end
    wr_en = 1'b1; wr_data = 32'hDEAD;
    step();
    wr_en = 1'b0;
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd4);
    chk("ovf_head", out_data, 32'h81);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    chk("ovf_clr", 32'(overflow), 32'd0);
    clr_ovf = 1'b1; wr_en = 1'b1; wr_data = 32'hDEAD;
    step();
    clr_ovf = 1'b0; wr_en = 1'b0;
    chk("ovf_set_wins", 32'(overflow), 32'd1);
    chk("ovf_count2", 32'(count), 32'd4);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    chk("ovf_clr2", 32'(overflow), 32'd0);

    // 5. Push and pop together when full, then at count 1
    wr_en = 1'b1; wr_data = 32'h77; out_ready = 1'b1;
    step();
    wr_en = 1'b0; out_ready = 1'b0;
    chk("pp_full_count", 32'(count), 32'd4);
    chk("pp_full_head", out_data, 32'h82);
    chk("pp_full_ovf", 32'(overflow), 32'd0);
    seq[0] = 32'h82; seq[1] = 32'h83; seq[2] = 32'h84; seq[3] = 32'h77;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("pp_seq", out_data, seq[i]);
      step();
    end
    out_ready = 1'b0;
    chk("pp_empty", 32'(empty), 32'd1);
    wr_en = 1'b1; wr_data = 32'h90;
    step();
    chk("pp1_count_a", 32'(count), 32'd1);
    wr_data = 32'h91; out_ready = 1'b1;
    step();
    wr_en = 1'b0;
    chk("pp1_count_b", 32'(count), 32'd1);
    chk("pp1_head", out_data, 32'h91);
    step();
    out_ready = 1'b0;
    chk("pp1_empty", 32'(empty), 32'd1);

    // 6. Streaming with consumer always ready
    out_ready = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      wr_en = 1'b1; wr_data = 32'(i);
      step();
      chk("stream_data", out_data, 32'(i));
      chk("stream_count", 32'(count), 32'd1);
    end
    wr_en = 1'b0;
    step();
    out_ready = 1'b0;
    chk("stream_empty", 32'(empty), 32'd1);
    chk("stream_ovf", 32'(overflow), 32'd0);

    // 1b. Asynchronous reset with words queued
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = 32'hA0 + 32'(i);
      step();
    end
    wr_en = 1'b0;
    chk("mid_count", 32'(count), 32'd3);
    #2 reset = 1'b0;
    #1;
    chk("async_count", 32'(count), 32'd0);
    chk("async_valid", 32'(out_valid), 32'd0);
    chk("async_data", out_data, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    step();
    chk("post_rst_empty", 32'(empty), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/out_port_fifo.md
Name: out_port_fifo

Overview:
- Output-port counterpart to the datapath's input port (IPortInput): the CPU writes words out through this block, and an external consumer or testbench reads them.
- CPU side: the out-instruction write strobe plus 32-bit bus data.
- External side: a valid/ready stream.
- A small FIFO decouples the two sides. A full flag lets control logic stall the CPU, and a sticky overflow flag records writes that were lost.

Parameters:
- WIDTH, 32, data word width; matches the datapath bus.
- DEPTH, 4, FIFO entries; must be a power of two, minimum 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- wr_en  input  1  CPU write strobe (OutPort enable); sampled on the rising edge.
- wr_data  input  WIDTH  word from BusMuxOut.
- clr_ovf  input  1  synchronous clear of the overflow flag.
- out_valid  output  1  out_data holds a valid word.
- out_ready  input  1  consumer accepts the word.
- out_data  output  WIDTH  head-of-FIFO word (first-word fall-through).
- full  output  1  count == DEPTH; CPU stall request.
- empty  output  1  count == 0.
- count  output  CNT_W  current occupancy.
- overflow  output  1  sticky; a write was dropped.

Behaviour:
- Reset (reset low, asynchronous):
  - rd_ptr, wr_ptr and count go to 0; overflow goes to 0.
  - out_valid = 0, empty = 1, full = 0, out_data = 0.
  - Storage contents need not be cleared.
  - Release of reset is synchronous to clock.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. There is no extra wrap bit; full/empty derive from count.
- pop = out_valid && out_ready.
- push = wr_en && (!full || pop).
  - Pushing while full is allowed only when a pop occurs in the same cycle.
- Edge updates:
  - push: mem[wr_ptr] <= wr_data; wr_ptr += 1.
  - pop: rd_ptr += 1.
  - count += push - pop. With push and pop together, count is unchanged.
- out_valid = !empty, combinational from the count register.
- out_data = mem[rd_ptr] when !empty, else 0.
- Latency: a word written at edge N is visible on out_data/out_valid after edge N. This is zero-cycle fall-through from the registered state.
- Empty with wr_en and out_ready both high: the word is pushed only, not bypassed. It is popped on the next cycle.
- Overflow:
  - Set at an edge where wr_en && full && !pop; the word is dropped and state is unchanged.
  - clr_ovf clears the flag.
  - If set and clear occur in the same cycle, set wins.
- out_data stability: while out_valid && !out_ready, out_data and out_valid must not change. A push into the tail does not disturb the head.
- out_ready while empty has no effect.
- Reset asserted mid-transfer: all pending words are discarded and out_valid drops immediately (asynchronously).
- full and empty are pure decodes of count. There are no combinational paths from wr_en to any output. The path from out_ready reaches only internal push logic.

Decomposition:
- Shared package datapath_pkg holds:
  - WORD_W = 32.
  - OUTPORT_DEPTH default.
  - typedef word_t (logic [WORD_W-1:0]).
- One natural sub-module, fifo_mem: DEPTH x WIDTH register array with a synchronous write port and an asynchronous read port.
- Pointer, count and flag logic stays in out_port_fifo.

Test Plan:
1. Reset check: reset low at t=0, then released.
   - During reset: out_valid=0, empty=1, full=0, count=0, overflow=0.
   - Pulse reset low mid-stream with 3 words queued: count→0 and out_valid→0 without waiting for a clock edge.
2. Ordered single write/read: out_ready=0, write 0x0000_00A5.
   - Next cycle: out_valid=1, out_data=0x0000_00A5, count=1.
   - Hold out_ready=0 for 5 cycles: data is stable.
   - Raise out_ready for 1 cycle: empty=1.
3. Fill and wrap: out_ready=0, write 0x11, 0x22, 0x33, 0x44.
   - full=1, count=4.
   - Drain 2 words: 0x11, 0x22 are read.
   - Write 0x55, 0x66: pointers wrap.
   - Drain the rest: sequence is 0x33, 0x44, 0x55, 0x66.
4. Overflow: with full=1 and out_ready=0, write 0xDEAD.
   - overflow=1, count stays 4, 0xDEAD never appears on out_data.
   - Pulse clr_ovf: overflow=0.
   - Pulse clr_ovf and an overflowing write in the same cycle: overflow=1.
5. Simultaneous push and pop:
   - When full, write 0x77 with out_ready=1: count stays 4, head advances, and 0x77 emerges last.
   - When count=1, write and pop together: count stays 1.
6. Streaming: out_ready=1 continuously, write 0x1..0x20 on every cycle.
   - All 32 words arrive in order, count never exceeds 1, overflow stays 0.
